// File: rtl/key_round_sequencer.sv
// key_round_sequencer: AES-128 round-key sequencer (encrypt/decrypt order) using a borrowed shared S-box
module key_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dec,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         sbox_req,
  input  logic         sbox_gnt,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] STEP = 2'd3;
  localparam logic [3:0] LAST = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? {1'b1, x[7:1] ^ 7'h0d} : {1'b0, x[7:1]};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rc_q, rc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         dec_q, dec_d;
  logic [31:0]  w0, w1, w2, w3, t, sel_w, f0, f1, f2, f3;
  logic [127:0] fwd_key, inv_key;
  logic         gnt, last, rev;

  assign {w0, w1, w2, w3} = key_q;
  assign rev      = dec_q && state_q == STEP;
  assign sel_w    = rev ? w3 ^ w2 : w3;
  assign sbox_req = state_q == PRE || state_q == STEP;
  assign sub_in   = sbox_req ? {sel_w[23:0], sel_w[31:24]} : '0;
  assign gnt      = sbox_req && sbox_gnt;
  assign t        = sub_out ^ {rc_q, 24'h0};
  assign f0       = w0 ^ t;
  assign f1       = w1 ^ f0;
  assign f2       = w2 ^ f1;
  assign f3       = w3 ^ f2;
  assign fwd_key  = {f0, f1, f2, f3};
  assign inv_key  = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  assign last     = dec_q ? cnt_q == 4'd0 : cnt_q == LAST;

  assign busy     = state_q != IDLE;
  assign rk_valid = state_q == EMIT;
  assign rk_out   = rk_valid ? key_q : '0;
  assign rk_round = rk_valid ? cnt_q : '0;
  assign rk_last  = rk_valid && last;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: if (start) begin
        key_d   = key_in;
        dec_d   = dec;
        rc_d    = 8'h01;
        cnt_d   = 4'd0;
        state_d = dec ? PRE : EMIT;
      end
      PRE: if (gnt) begin
        key_d   = fwd_key;
        rc_d    = cnt_q == LAST - 4'd1 ? 8'h36 : xtime(rc_q);
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == LAST - 4'd1 ? EMIT : PRE;
      end
      EMIT: if (rk_ready) state_d = last ? IDLE : STEP;
      STEP: if (gnt) begin
        key_d   = dec_q ? inv_key : fwd_key;
        rc_d    = dec_q ? inv_xtime(rc_q) : xtime(rc_q);
        cnt_d   = dec_q ? cnt_q - 4'd1 : cnt_q + 4'd1;
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end
endmodule
